regfile_write_queue: RTL and testbench

- Initiator for the 8x32 register file write port (write_reg / write_data / reg_write).
- Accepts writeback requests from multi-cycle datapath units over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one register-file write per cycle.
- Provides two read-side lookup ports that report whether a register has a pending, not-yet-committed write, and return the youngest pending value for forwarding.

---
 rtl/regfile_write_queue.sv | 101 ++++++++++
 tb/tb_regfile_write_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// Buffers writeback requests and drains them in order into the register file, one write per cycle, with forwarding lookups.
// Push at edge N -> write issued cycle N+1..N+2 at the earliest; in_ready=!full, and rf_ready=0 holds the queue.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rf_ready,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  input  logic [ADDR_W-1:0] lookup_reg1,
  input  logic [ADDR_W-1:0] lookup_reg2,
  output logic              hit1,
  output logic              hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] ent_reg  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic push;
  logic pop;

  assign empty    = (count == '0);
  assign full     = (count == (ADDR_W+1)'(DEPTH));
  assign in_ready = !full;
  // Push is gated by the registered full flag, so a same-edge pop never frees a slot for it.
  assign push     = in_valid && in_ready;
  assign pop      = !empty && rf_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ent_vld    <= '0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        ent_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        ent_vld[rd_ptr] <= 1'b0;
        write_reg       <= ent_reg[rd_ptr];
        write_data      <= ent_data[rd_ptr];
      end
      reg_write <= pop;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[wr_ptr]  <= in_reg;
      ent_data[wr_ptr] <= in_data;
    end
  end

  // Scan oldest to youngest so the youngest match overwrites; the output stage is older than every entry.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] r);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (reg_write && (write_reg == r)) res = {1'b1, write_data};
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (ent_vld[idx] && (ent_reg[idx] == r)) res = {1'b1, ent_data[idx]};
    end
    return res;
  endfunction

  always_comb begin
    {hit1, fwd_data1} = lookup(lookup_reg1);
    {hit2, fwd_data2} = lookup(lookup_reg2);
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: handshake, in-order drain, forwarding lookups and reset flush.
module tb_regfile_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_reg;
  logic [31:0] in_data;
  logic        rf_ready;
  logic [2:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [2:0]  lookup_reg1;
  logic [2:0]  lookup_reg2;
  logic        hit1;
  logic        hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int total = 0;
  int bad   = 0;

  regfile_write_queue #(.DEPTH(4), .ADDR_W(3), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .rf_ready(rf_ready),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .lookup_reg1(lookup_reg1), .lookup_reg2(lookup_reg2),
    .hit1(hit1), .hit2(hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; comparisons follow a further settle delay.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_reg = 3'd7; in_data = 32'h77;
    rf_ready = 1'b1; lookup_reg1 = 3'd0; lookup_reg2 = 3'd7;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_ignored_push_hit2", hit2, 0);

    // Single request: visible to lookup only after its push edge
    in_valid = 1'b1; in_reg = 3'd3; in_data = 32'hDEADBEEF; lookup_reg1 = 3'd3;
    #1;
    chk("single_pre_hit1", hit1, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("single_e1_count", count, 1);
    chk("single_e1_reg_write", reg_write, 0);
    chk("single_e1_hit1", hit1, 1);
    chk("single_e1_fwd1", fwd_data1, 32'hDEADBEEF);
    tick(); #1;
    chk("single_e2_reg_write", reg_write, 1);
    chk("single_e2_write_reg", write_reg, 3);
    chk("single_e2_write_data", write_data, 32'hDEADBEEF);
    chk("single_e2_count", count, 0);
    chk("single_e2_hit1", hit1, 1);
    chk("single_e2_fwd1", fwd_data1, 32'hDEADBEEF);
    tick(); #1;
    chk("single_e3_reg_write", reg_write, 0);
    chk("single_e3_write_reg_hold", write_reg, 3);
    chk("single_e3_hit1", hit1, 0);
    chk("single_e3_fwd1", fwd_data1, 0);

    // Fill while stalled
    rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_reg = 3'(i); in_data = 32'(i * 'h11);
      tick();
    end
    in_valid = 1'b1; in_reg = 3'd7; in_data = 32'h77;
    lookup_reg1 = 3'd4; lookup_reg2 = 3'd7;
    #1;
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 4);
    chk("fill_hit1", hit1, 1);
    chk("fill_fwd1", fwd_data1, 32'h44);
    tick(); #1;
    chk("fill_5th_count", count, 4);
    chk("fill_stall_reg_write", reg_write, 0);
    chk("fill_5th_hit2", hit2, 0);
    // Pop on the same edge must not admit the waiting request
    rf_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("drain0_count", count, 3);
    chk("drain0_reg_write", reg_write, 1);
    chk("drain0_write_reg", write_reg, 1);
    chk("drain0_write_data", write_data, 32'h11);
    for (int i = 2; i <= 4; i++) begin
      tick(); #1;
      chk("drain_reg_write", reg_write, 1);
      chk("drain_write_reg", write_reg, 64'(i));
      chk("drain_write_data", write_data, 64'(i * 'h11));
      chk("drain_count", count, 64'(4 - i));
    end
    chk("drain_no_reg7", hit2, 0);
    tick(); #1;
    chk("drain_done_reg_write", reg_write, 0);

    // Two writes to the same register: youngest forwarded, both issued in order
    rf_ready = 1'b0; lookup_reg2 = 3'd5;
    in_valid = 1'b1; in_reg = 3'd5; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    #1;
    chk("same_first_fwd2", fwd_data2, 32'hA);
    tick();
    in_valid = 1'b0;
    #1;
    chk("same_hit2", hit2, 1);
    chk("same_fwd2", fwd_data2, 32'hB);
    chk("same_count", count, 2);
    rf_ready = 1'b1;
    tick(); #1;
    chk("same_w1_data", write_data, 32'hA);
    chk("same_w1_reg", write_reg, 5);
    chk("same_w1_fwd2", fwd_data2, 32'hB);
    tick(); #1;
    chk("same_w2_reg_write", reg_write, 1);
    chk("same_w2_data", write_data, 32'hB);
    chk("same_w2_fwd2", fwd_data2, 32'hB);
    tick(); #1;
    chk("same_done_reg_write", reg_write, 0);
    chk("same_done_hit2", hit2, 0);

    // Streaming push+pop across pointer wrap
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_reg = 3'(k % 8); in_data = 32'h100 + 32'(k);
      tick(); #1;
      chk("stream_count", count, 1);
      if (k == 0) begin
        chk("stream_first_reg_write", reg_write, 0);
      end else begin
        chk("stream_reg_write", reg_write, 1);
        chk("stream_write_data", write_data, 64'h100 + 64'(k - 1));
        chk("stream_write_reg", write_reg, 64'((k - 1) % 8));
      end
    end
    in_valid = 1'b0;
    tick(); #1;
    chk("stream_last_data", write_data, 32'h109);
    chk("stream_last_count", count, 0);
    tick(); #1;
    chk("stream_idle_reg_write", reg_write, 0);

    // Reset flush with a busy queue
    rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_reg = 3'(i); in_data = 32'h200 + 32'(i);
      tick();
    end
    in_valid = 1'b0; rf_ready = 1'b1;
    tick(); #1;
    chk("pre_rst_count", count, 3);
    chk("pre_rst_reg_write", reg_write, 1);
    rst = 1'b1; lookup_reg1 = 3'd1; lookup_reg2 = 3'd2;
    tick();
    rst = 1'b0;
    #1;
    chk("flush_reg_write", reg_write, 0);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_hit1", hit1, 0);
    chk("flush_hit2", hit2, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("flush_no_stale_write", reg_write, 0);
    end

    // Lookup miss next to a pending write on another register, while stalled
    rf_ready = 1'b0;
    in_valid = 1'b1; in_reg = 3'd2; in_data = 32'h5;
    tick();
    in_valid = 1'b0; lookup_reg1 = 3'd6; lookup_reg2 = 3'd2;
    #1;
    chk("miss_hit1", hit1, 0);
    chk("miss_fwd1", fwd_data1, 0);
    chk("stall_hit2", hit2, 1);
    chk("stall_fwd2", fwd_data2, 32'h5);
    tick(); #1;
    chk("stall_reg_write", reg_write, 0);
    chk("stall_count", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
